// File: rtl/wb_ram_slave_pkg.sv
// Shared Wishbone types and helpers for the on-chip RAM responder.
package wb_ram_slave_pkg;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_INCR    = 3'b010,
    CTI_END     = 3'b111
  } wb_cti_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RESP  = 2'd2,
    BURST = 2'd3
  } wb_slave_state_t;

  localparam int WAIT_CNT_W = 4;

  function automatic logic word_aligned(input logic [1:0] adr_lsb);
    return adr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/wb_ram_array.sv
// Synchronous single-port word RAM with registered read.
module wb_ram_array #(
  parameter int    ADDR_WIDTH = 10,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           din,
  output logic [31:0]           dout
);

  logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone B4 classic slave in front of a word-addressed on-chip RAM:
// programmable wait states, ERR on bad addresses, incrementing read bursts.
//
// state | meaning
// IDLE  | waiting for CYC&STB; address is checked only here
// WAIT  | counting wait states before the first response
// RESP  | first (or only) ACK, or an ERR, is on the bus
// BURST | further read-burst beats, one per cycle
module wb_ram_slave
  import wb_ram_slave_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_STATES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CYC,
  input  logic        STB,
  input  logic        WE,
  input  logic [31:0] ADR,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  input  logic [2:0]  CTI_I,
  output logic        ACK,
  output logic        ERR,
  output logic        RTY
);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_WAIT  = WAIT;
  localparam logic [1:0] ST_RESP  = RESP;
  localparam logic [1:0] ST_BURST = BURST;

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
    (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

  logic [1:0]            state;
  logic [WAIT_CNT_W-1:0] cnt;
  logic [ADDR_WIDTH:0]   bidx;
  logic                  rd_vld;
  logic [31:0]           dat_q;

  logic                  req;
  logic                  addr_ok;
  logic                  enter_resp;
  logic                  burst_go;
  logic                  in_beat;
  logic [31:0]           off;
  logic [ADDR_WIDTH-1:0] idx;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [31:0]           ram_dout;

  assign req     = CYC & STB;
  assign off     = ADR - BASE_ADDR;
  assign idx     = off[ADDR_WIDTH+1:2];
  assign addr_ok = word_aligned(ADR[1:0]) && (ADR >= BASE_ADDR) &&
                   ((off >> (ADDR_WIDTH + 2)) == 32'd0);

  assign in_beat = (state == ST_RESP) || (state == ST_BURST);

  // The access happens on the edge that enters RESP, so the RAM sees the write
  // and the read address one cycle before ACK is visible.
  assign enter_resp = req &&
                      (((state == ST_IDLE) && addr_ok && (WAIT_STATES == 0)) ||
                       ((state == ST_WAIT) && (cnt == '0)));

  assign burst_go = req && ACK && !WE && (CTI_I == CTI_INCR) && in_beat;
  assign ram_we   = enter_resp && WE && !rst;

  // During beats the RAM is already fetching the next index.
  assign ram_addr = in_beat ? bidx[ADDR_WIDTH-1:0] : idx;

  wb_ram_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .din  (DAT_I),
    .dout (ram_dout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      ACK    <= 1'b0;
      ERR    <= 1'b0;
      cnt    <= '0;
      bidx   <= '0;
      rd_vld <= 1'b0;
      dat_q  <= '0;
    end else begin
      ACK    <= 1'b0;
      ERR    <= 1'b0;
      rd_vld <= 1'b0;
      if (rd_vld) dat_q <= ram_dout;

      if (enter_resp) begin
        state  <= ST_RESP;
        ACK    <= 1'b1;
        rd_vld <= !WE;
        bidx   <= {1'b0, idx} + 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (req) begin
              if (!addr_ok) begin
                state <= ST_RESP;
                ERR   <= 1'b1;
              end else begin
                state <= ST_WAIT;
                cnt   <= WAIT_INIT;
              end
            end
          end
          ST_WAIT: begin
            if (!req) state <= ST_IDLE;
            else      cnt   <= cnt - 1'b1;
          end
          default: begin
            if (burst_go) begin
              // Running past the top word ends the burst with ERR, never wraps.
              if (bidx[ADDR_WIDTH]) begin
                state <= ST_RESP;
                ERR   <= 1'b1;
              end else begin
                state  <= ST_BURST;
                ACK    <= 1'b1;
                rd_vld <= 1'b1;
                bidx   <= bidx + 1'b1;
              end
            end else begin
              state <= ST_IDLE;
            end
          end
        endcase
      end
    end
  end

  // Read data is live from the RAM on a read beat and held otherwise.
  assign DAT_O = rd_vld ? ram_dout : dat_q;
  assign RTY   = 1'b0;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Randomized self-checking bench for wb_ram_slave against a transaction-level model.
module tb_wb_ram_slave;

  localparam int AW    = 10;
  localparam int WS    = 1;
  localparam int DEPTH = 1 << AW;

  logic        clk = 1'b0;
  logic        rst;
  logic        CYC, STB, WE;
  logic [31:0] ADR, DAT_I, DAT_O;
  logic [2:0]  CTI_I;
  logic        ACK, ERR, RTY;

  wb_ram_slave #(
    .ADDR_WIDTH  (AW),
    .BASE_ADDR   (32'h0),
    .WAIT_STATES (WS),
    .INIT_FILE   ("")
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .CYC   (CYC),
    .STB   (STB),
    .WE    (WE),
    .ADR   (ADR),
    .DAT_I (DAT_I),
    .DAT_O (DAT_O),
    .CTI_I (CTI_I),
    .ACK   (ACK),
    .ERR   (ERR),
    .RTY   (RTY)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc;
  bit chk_en = 1'b0;

  logic        exp_ack, exp_err;
  logic [31:0] exp_dat;
  logic [31:0] mdl [0:DEPTH-1];

  logic [31:0] beats [$];
  logic [31:0] seen_dat;
  int first_ack, last_ack, first_err, n_ack;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack", 32'(ACK), 32'(exp_ack));
      chk("err", 32'(ERR), 32'(exp_err));
      chk("dat", DAT_O, exp_dat);
      chk("rty", 32'(RTY), 32'd0);
      if (ACK === 1'b1) begin
        n_ack++;
        seen_dat = DAT_O;
        beats.push_back(DAT_O);
        if (first_ack < 0) first_ack = cyc;
        last_ack = cyc;
      end
      if (ERR === 1'b1 && first_err < 0) first_err = cyc;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a < 32'(4 * DEPTH));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mark();
    first_ack = -1;
    last_ack  = -1;
    first_err = -1;
    n_ack     = 0;
    beats.delete();
  endtask

  task automatic bus_idle(input int n);
    CYC = 1'b0; STB = 1'b0; WE = 1'b0; CTI_I = 3'b000;
    exp_ack = 1'b0; exp_err = 1'b0;
    repeat (n) step();
  endtask

  // Response appears WS+1 cycles after the request; illegal addresses answer in one.
  task automatic classic(input bit we, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] cti);
    CYC = 1'b1; STB = 1'b1; WE = we; ADR = a; DAT_I = d; CTI_I = cti;
    exp_ack = 1'b0; exp_err = 1'b0;
    start_cyc = cyc;
    if (!legal(a)) begin
      step();
      exp_err = 1'b1;
    end else begin
      repeat (WS) step();
      step();
      exp_ack = 1'b1;
      if (we) mdl[a >> 2] = d;
      else    exp_dat = mdl[a >> 2];
    end
    step();
    CYC = 1'b0; STB = 1'b0; exp_ack = 1'b0; exp_err = 1'b0;
  endtask

  task automatic burst(input logic [31:0] a, input int n);
    int idx;
    idx = int'(a >> 2);
    CYC = 1'b1; STB = 1'b1; WE = 1'b0; ADR = a;
    CTI_I = (n > 1) ? 3'b010 : 3'b111;
    exp_ack = 1'b0; exp_err = 1'b0;
    start_cyc = cyc;
    repeat (WS) step();
    for (int k = 0; k < n; k++) begin
      step();
      ADR   = a + 32'(4 * k);
      CTI_I = (k < n - 1) ? 3'b010 : 3'b111;
      if (idx + k >= DEPTH) begin
        exp_ack = 1'b0;
        exp_err = 1'b1;
        break;
      end
      exp_ack = 1'b1;
      exp_err = 1'b0;
      exp_dat = mdl[idx + k];
    end
    step();
    CYC = 1'b0; STB = 1'b0; CTI_I = 3'b000; exp_ack = 1'b0; exp_err = 1'b0;
  endtask

  task automatic abort_wait(input bit we, input logic [31:0] a, input logic [31:0] d,
                            input bit drop_cyc);
    CYC = 1'b1; STB = 1'b1; WE = we; ADR = a; DAT_I = d; CTI_I = 3'b000;
    exp_ack = 1'b0; exp_err = 1'b0;
    step();
    if (drop_cyc) CYC = 1'b0;
    else          STB = 1'b0;
    step();
    CYC = 1'b0; STB = 1'b0;
  endtask

  initial begin
    int op, n;
    logic [31:0] a, d;
    bit w;

    rst = 1'b1; CYC = 1'b0; STB = 1'b0; WE = 1'b0;
    ADR = '0; DAT_I = '0; CTI_I = 3'b000;
    exp_ack = 1'b0; exp_err = 1'b0; exp_dat = '0;
    mark();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_ack", 32'(ACK), 32'd0);
    chk("reset_err", 32'(ERR), 32'd0);
    chk("reset_dat", DAT_O, 32'd0);

    for (int i = 0; i < DEPTH; i++) classic(1'b1, 32'(i) << 2, $urandom, 3'b000);

    // Write then read back with two-cycle latency.
    mark();
    classic(1'b1, 32'h10, 32'hDEADBEEF, 3'b000);
    chk("t1_wr_latency", 32'(first_ack - start_cyc), 32'd2);
    mark();
    classic(1'b0, 32'h10, 32'h0, 3'b000);
    chk("t1_rd_latency", 32'(first_ack - start_cyc), 32'd2);
    chk("t1_rd_data", seen_dat, 32'hDEADBEEF);

    // Out of range read.
    mark();
    classic(1'b0, 32'h1000, 32'h0, 3'b000);
    chk("t2_err_latency", 32'(first_err - start_cyc), 32'd1);
    chk("t2_no_ack", 32'(n_ack), 32'd0);

    // Misaligned write must not touch RAM.
    mark();
    classic(1'b1, 32'h12, 32'hCAFE0000, 3'b000);
    chk("t3_err_latency", 32'(first_err - start_cyc), 32'd1);
    chk("t3_no_ack", 32'(n_ack), 32'd0);
    mark();
    classic(1'b0, 32'h10, 32'h0, 3'b000);
    chk("t3_reread", seen_dat, 32'hDEADBEEF);

    // Four-beat incrementing burst.
    for (int k = 0; k < 4; k++) classic(1'b1, 32'h20 + 32'(4 * k), 32'(k + 1), 3'b000);
    mark();
    burst(32'h20, 4);
    chk("t4_first_latency", 32'(first_ack - start_cyc), 32'd2);
    chk("t4_ack_span", 32'(last_ack - first_ack), 32'd3);
    chk("t4_nbeats", 32'(beats.size()), 32'd4);
    for (int k = 0; k < beats.size() && k < 4; k++) chk("t4_beat", beats[k], 32'(k + 1));

    // Write aborted while waiting.
    classic(1'b1, 32'h30, 32'h12345678, 3'b000);
    mark();
    abort_wait(1'b1, 32'h30, 32'h55, 1'b0);
    chk("t5_no_ack", 32'(n_ack), 32'd0);
    mark();
    classic(1'b0, 32'h30, 32'h0, 3'b000);
    chk("t5_unchanged", seen_dat, 32'h12345678);

    // Reset on the second beat of a burst.
    CYC = 1'b1; STB = 1'b1; WE = 1'b0; ADR = 32'h20; CTI_I = 3'b010;
    exp_ack = 1'b0; exp_err = 1'b0;
    repeat (WS) step();
    step();
    exp_ack = 1'b1; exp_dat = mdl[8];
    step();
    ADR = 32'h24; exp_dat = mdl[9];
    rst = 1'b1;
    step();
    rst = 1'b0; CYC = 1'b0; STB = 1'b0; CTI_I = 3'b000;
    exp_ack = 1'b0; exp_err = 1'b0; exp_dat = 32'h0;
    chk("t6_ack_after_rst", 32'(ACK), 32'd0);
    chk("t6_dat_after_rst", DAT_O, 32'd0);
    step();
    mark();
    classic(1'b0, 32'h24, 32'h0, 3'b000);
    chk("t6_reread", seen_dat, 32'd2);

    // Reset on the edge that would commit a write.
    classic(1'b1, 32'h40, 32'hA5A5A5A5, 3'b000);
    CYC = 1'b1; STB = 1'b1; WE = 1'b1; ADR = 32'h40; DAT_I = 32'hFFFF0000;
    exp_ack = 1'b0; exp_err = 1'b0;
    repeat (WS) step();
    rst = 1'b1;
    step();
    rst = 1'b0; CYC = 1'b0; STB = 1'b0; exp_dat = 32'h0;
    step();
    mark();
    classic(1'b0, 32'h40, 32'h0, 3'b000);
    chk("t6_write_suppressed", seen_dat, 32'hA5A5A5A5);

    for (int it = 0; it < 400; it++) begin
      op = int'($urandom_range(0, 9));
      a  = 32'($urandom_range(0, DEPTH - 1)) << 2;
      d  = $urandom;
      w  = bit'($urandom_range(0, 1));
      case (op)
        0, 1: classic(1'b1, a, d, w ? 3'b010 : 3'b000);
        2, 3, 9: classic(1'b0, a, d, 3'b000);
        4: begin
          if ($urandom_range(0, 1) == 0) a = a | 32'($urandom_range(1, 3));
          else a = 32'(4 * DEPTH) + (32'($urandom_range(0, 4095)) << 2);
          classic(w, a, d, 3'b000);
        end
        5, 6: begin
          if ($urandom_range(0, 2) == 0) a = 32'(DEPTH - int'($urandom_range(1, 4))) << 2;
          n = int'($urandom_range(1, 6));
          burst(a, n);
        end
        7: abort_wait(w, a, d, bit'($urandom_range(0, 1)));
        default: bus_idle(int'($urandom_range(1, 3)));
      endcase
    end

    bus_idle(3);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
